// File: rtl/rx_align_pkg.sv
// Shared types and comma codes for the 10b receive word-alignment path.
package rx_align_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_t;

  localparam logic [9:0] K28_5_RDN = 10'h17C;
  localparam logic [9:0] K28_5_RDP = 10'h283;

endpackage

// File: rtl/rx_comma_detect.sv
// Combinational comma compare on a 10-bit window; extend here for other comma sets.
module rx_comma_detect
  import rx_align_pkg::*;
(
  input  logic [9:0] win,
  output logic       match
);

  assign match = (win == K28_5_RDN) || (win == K28_5_RDP);

endmodule

// File: rtl/rx_word_align_ctrl.sv
// Bit-clock word-alignment controller: comma hunt, lock verify and loss handling.
// Optional lock watchdog enabled by defining RX_ALIGN_WATCHDOG_EN.
//
// state  | meaning
// HUNT   | no word boundary known, waiting for any comma
// VERIFY | boundary set by a comma, counting aligned commas toward lock
// LOCKED | boundary trusted, counting misaligned commas toward loss
module rx_word_align_ctrl
  import rx_align_pkg::*;
#(
  parameter int LOCK_CNT   = 3,
  parameter int LOSS_CNT   = 4,
  parameter int WDOG_WORDS = 1024
) (
  input  logic       BitCLK,
  input  logic       Reset_n,
  input  logic       Serial,
  output logic [9:0] RxParallel_10,
  output logic       RxValid,
  output logic       CommaDet,
  output logic       Aligned,
  output logic [1:0] AlignState
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);

  align_state_t  state_q, state_d;
  logic [9:0]    sh_q;
  logic [3:0]    phase_q, phase_d;
  logic [GW-1:0] good_q, good_d;
  logic [BW-1:0] bad_q, bad_d;
  logic [9:0]    par_q, par_d;
  logic          valid_q, valid_d;
  logic          comma_q, comma_d;
  logic [9:0]    win;
  logic          match;
  logic          boundary;
  logic          realign;

`ifdef RX_ALIGN_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_WORDS + 1);
  logic [WW-1:0] wdog_q, wdog_d;
`else
  logic          unused_wdog_words;
  assign unused_wdog_words = (WDOG_WORDS > 0);
`endif

  assign win      = {Serial, sh_q[9:1]};
  assign boundary = (phase_q == 4'd9);

  rx_comma_detect u_comma_detect (
    .win   (win),
    .match (match)
  );

  always_comb begin
    state_d = state_q;
    phase_d = boundary ? 4'd0 : phase_q + 4'd1;
    good_d  = good_q;
    bad_d   = bad_q;
    par_d   = par_q;
    valid_d = 1'b0;
    comma_d = comma_q;
    realign = 1'b0;
`ifdef RX_ALIGN_WATCHDOG_EN
    wdog_d  = wdog_q;
`endif

    case (state_q)
      HUNT: begin
        if (match) realign = 1'b1;
      end
      VERIFY: begin
        if (boundary) begin
          par_d   = win;
          valid_d = 1'b1;
          comma_d = match;
          if (match) begin
            if (good_q != GW'(LOCK_CNT)) good_d = good_q + 1'b1;
            if (int'(good_q) + 1 >= LOCK_CNT) begin
              state_d = LOCKED;
              bad_d   = '0;
            end
          end
        end else if (match) begin
          realign = 1'b1;
        end
      end
      LOCKED: begin
        if (boundary) begin
          par_d   = win;
          valid_d = 1'b1;
          comma_d = match;
          if (match) begin
            bad_d = '0;
`ifdef RX_ALIGN_WATCHDOG_EN
            wdog_d = '0;
          end else if (int'(wdog_q) + 1 >= WDOG_WORDS) begin
            // Phase keeps running so HUNT still sees every bit offset.
            state_d = HUNT;
            good_d  = '0;
            bad_d   = '0;
            wdog_d  = '0;
          end else begin
            wdog_d = wdog_q + 1'b1;
`endif
          end
        end else if (match) begin
          if (int'(bad_q) + 1 >= LOSS_CNT) realign = 1'b1;
          else                             bad_d   = bad_q + 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase

    if (realign) begin
      phase_d = 4'd0;
      par_d   = win;
      valid_d = 1'b1;
      comma_d = 1'b1;
      good_d  = GW'(1);
      bad_d   = '0;
      state_d = (LOCK_CNT == 1) ? LOCKED : VERIFY;
`ifdef RX_ALIGN_WATCHDOG_EN
      wdog_d  = '0;
`endif
    end
  end

  always_ff @(posedge BitCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= HUNT;
      sh_q    <= '0;
      phase_q <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      par_q   <= '0;
      valid_q <= 1'b0;
      comma_q <= 1'b0;
`ifdef RX_ALIGN_WATCHDOG_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= win;
      phase_q <= phase_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      par_q   <= par_d;
      valid_q <= valid_d;
      comma_q <= comma_d;
`ifdef RX_ALIGN_WATCHDOG_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

  assign RxParallel_10 = par_q;
  assign RxValid       = valid_q;
  assign CommaDet      = comma_q;
  assign Aligned       = (state_q == LOCKED);
  assign AlignState    = state_q;

endmodule

// File: tb/tb_rx_word_align_ctrl.sv
// Directed + randomized bench for rx_word_align_ctrl against a cycle-count based reference model.
module tb_rx_word_align_ctrl;

  localparam int LOCK_CNT   = 3;
  localparam int LOSS_CNT   = 4;
  localparam int WDOG_WORDS = 8;

  logic       BitCLK = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Serial = 1'b0;
  logic [9:0] RxParallel_10;
  logic       RxValid;
  logic       CommaDet;
  logic       Aligned;
  logic [1:0] AlignState;

  rx_word_align_ctrl #(
    .LOCK_CNT   (LOCK_CNT),
    .LOSS_CNT   (LOSS_CNT),
    .WDOG_WORDS (WDOG_WORDS)
  ) dut (
    .BitCLK        (BitCLK),
    .Reset_n       (Reset_n),
    .Serial        (Serial),
    .RxParallel_10 (RxParallel_10),
    .RxValid       (RxValid),
    .CommaDet      (CommaDet),
    .Aligned       (Aligned),
    .AlignState    (AlignState)
  );

  always #5 BitCLK = ~BitCLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: word boundaries are every 10th edge counted from the
  // last realign (or reset); the window is the last 10 received bits.
  bit         hist[$];
  int         cyc, base, m_state, m_good, m_bad, m_wdog;
  logic [9:0] e_par;
  logic       e_valid, e_comma;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < 9; i++) hist.push_back(1'b0);
    cyc = 0; base = 0;
    m_state = 0; m_good = 0; m_bad = 0; m_wdog = 0;
    e_par = '0; e_valid = 1'b0; e_comma = 1'b0;
  endfunction

  function automatic void model_realign(input logic [9:0] w);
    base = cyc;
    e_par = w; e_valid = 1'b1; e_comma = 1'b1;
    m_good = 1; m_bad = 0; m_wdog = 0;
    m_state = (LOCK_CNT == 1) ? 2 : 1;
  endfunction

  function automatic void model_step(input bit b);
    logic [9:0] w;
    bit match, bnd;
    cyc++;
    hist.push_back(b);
    for (int i = 0; i < 10; i++) w[i] = hist[i];
    void'(hist.pop_front());
    match = (w == 10'h17C) || (w == 10'h283);
    bnd = ((cyc - base) % 10) == 0;
    e_valid = 1'b0;
    if (m_state == 0) begin
      if (match) model_realign(w);
    end else if (bnd) begin
      e_par = w; e_valid = 1'b1; e_comma = match;
      if (match) begin
        m_bad = 0; m_wdog = 0;
        if (m_state == 1) begin
          if (m_good < LOCK_CNT) m_good++;
          if (m_good >= LOCK_CNT) m_state = 2;
        end
      end else if (m_state == 2) begin
`ifdef RX_ALIGN_WATCHDOG_EN
        m_wdog++;
        if (m_wdog >= WDOG_WORDS) begin
          m_state = 0; m_good = 0; m_bad = 0; m_wdog = 0;
        end
`endif
      end
    end else if (match) begin
      if (m_state == 1) model_realign(w);
      else begin
        m_bad++;
        if (m_bad >= LOSS_CNT) model_realign(w);
      end
    end
  endfunction

  task automatic send_bit(input bit b);
    @(negedge BitCLK);
    Serial = b;
    @(posedge BitCLK);
    model_step(b);
    #1;
    chk("valid", {9'd0, RxValid}, {9'd0, e_valid});
    chk("state", {8'd0, AlignState}, 10'(m_state));
    chk("aligned", {9'd0, Aligned}, {9'd0, (m_state == 2)});
    chk("commadet", {9'd0, CommaDet}, {9'd0, e_comma});
    chk("parallel", RxParallel_10, e_par);
  endtask

  task automatic send_word(input logic [9:0] w);
    for (int i = 0; i < 10; i++) send_bit(w[i]);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_par"}, RxParallel_10, 10'd0);
    chk({tag, "_valid"}, {9'd0, RxValid}, 10'd0);
    chk({tag, "_comma"}, {9'd0, CommaDet}, 10'd0);
    chk({tag, "_aligned"}, {9'd0, Aligned}, 10'd0);
    chk({tag, "_state"}, {8'd0, AlignState}, 10'd0);
  endtask

  task automatic do_reset(input int n, input string tag);
    Reset_n = 1'b0;
    #1;
    chk_zero({tag, "_assert"});
    repeat (n) @(posedge BitCLK);
    #1;
    chk_zero({tag, "_hold"});
    #1;
    Reset_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [9:0] rand_comma();
    return ($urandom_range(0, 1) == 0) ? 10'h17C : 10'h283;
  endfunction

  initial begin
    logic [9:0] w;
    int since_comma;

    // Reset and idle line
    do_reset(5, "rst_init");
    repeat (30) send_bit(1'b0);
    chk("idle_state", {8'd0, AlignState}, 10'd0);

    // Acquire lock on repeated K28.5 at a random offset
    repeat (3) send_bit(1'($urandom_range(0, 1)));
    send_word(10'h17C);
    chk("first_pulse", {9'd0, RxValid}, 10'd1);
    chk("first_comma", {9'd0, CommaDet}, 10'd1);
    chk("first_verify", {8'd0, AlignState}, 10'd1);
    send_word(10'h17C);
    chk("second_not_locked", {9'd0, Aligned}, 10'd0);
    send_word(10'h17C);
    chk("third_locked", {9'd0, Aligned}, 10'd1);
    repeat (3) send_word(10'h17C);

    // One-bit slip: four misaligned commas force realignment
    send_bit(1'($urandom_range(0, 1)));
    for (int k = 1; k <= 4; k++) begin
      send_word(10'h17C);
      if (k < 4) chk("slip_still_locked", {8'd0, AlignState}, 10'd2);
    end
    chk("slip_verify", {8'd0, AlignState}, 10'd1);
    chk("slip_aligned_drop", {9'd0, Aligned}, 10'd0);
    chk("slip_realign_pulse", {9'd0, RxValid}, 10'd1);
    send_word(10'h17C);
    send_word(10'h17C);
    chk("slip_relock", {8'd0, AlignState}, 10'd2);

    // Mixed commas of both disparities and data words
    since_comma = 0;
    for (int k = 0; k < 40; k++) begin
      case ((since_comma == 3) ? 0 : $urandom_range(0, 2))
        0:       w = 10'h17C;
        1:       w = 10'h283;
        default: w = 10'h2AA;
      endcase
      since_comma = (w == 10'h2AA) ? since_comma + 1 : 0;
      send_word(w);
      chk("mix_aligned", {9'd0, Aligned}, 10'd1);
      chk("mix_commadet", {9'd0, CommaDet}, {9'd0, (w != 10'h2AA)});
    end

    // Reset mid-word while locked, then relock
    for (int i = 0; i < 5; i++) send_bit(w[i]);
    #2;
    do_reset(3, "rst_mid");
    send_word(10'h17C);
    send_word(10'h283);
    chk("relock_pending", {9'd0, Aligned}, 10'd0);
    send_word(10'h17C);
    chk("relock_done", {9'd0, Aligned}, 10'd1);

    // Lock watchdog on a run of data words
    for (int k = 1; k <= WDOG_WORDS; k++) begin
      send_word(10'h2AA);
      if (k < WDOG_WORDS) chk("wdog_hold", {8'd0, AlignState}, 10'd2);
    end
`ifdef RX_ALIGN_WATCHDOG_EN
    chk("wdog_trip", {8'd0, AlignState}, 10'd0);
`else
    chk("wdog_absent", {8'd0, AlignState}, 10'd2);
`endif
    send_word(rand_comma());
    send_word(10'h2AA);

    // Random soak: commas at arbitrary offsets in random data
    do_reset(2, "rst_soak");
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 2) == 0) send_word(rand_comma());
      else repeat ($urandom_range(1, 12)) send_bit(1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_word_align_ctrl.md
# rx_word_align_ctrl

Receive-side word-alignment controller for the 10b SerDes receive path. Runs on the bit clock, shifts in the raw serial stream, hunts for K28.5 commas at any bit offset, and sequences the 10-bit word boundary so parallel words are emitted aligned to the comma. Sits between the CDR/serial input and the 8b/10b decoder. It replaces the free-running deserializer counter with a lock/verify/loss state machine.

## Interface
Parameters:
- LOCK_CNT, 3: consecutive boundary-aligned commas needed to declare lock (≥1)
- LOSS_CNT, 4: misaligned commas in LOCKED that force realignment (≥1)
- WDOG_WORDS, 1024: words without an aligned comma before lock is dropped (watchdog only)

Ports:
- BitCLK  in  1  bit clock, single clock domain
- Reset_n  in  1  asynchronous, active-low reset
- Serial  in  1  received serial bit, sampled on rising BitCLK
- RxParallel_10  out  10  aligned word; the first-received bit is in bit 0
- RxValid  out  1  one-cycle pulse when RxParallel_10 updates
- CommaDet  out  1  qualifies RxValid; the emitted word is a K28.5
- Aligned  out  1  high only in LOCKED
- AlignState  out  2  0=HUNT, 1=VERIFY, 2=LOCKED

## Operation
- Shift register: sh <= {Serial, sh[9:1]} every cycle. The window win = {Serial, sh[9:1]} is evaluated combinationally at each edge.
- Comma match: win == 10'h17C (K28.5 RD−) or 10'h283 (RD+). The match is exact on all 10 bits.
- Phase counter 0..9. Boundary = phase==9. At a boundary, phase wraps to 0. Otherwise it increments.
- At each boundary in VERIFY/LOCKED: RxParallel_10<=win, RxValid<=1, CommaDet<=match.
- Realign event (a match while not at the boundary, or any match in HUNT):
  - phase<=0
  - RxParallel_10<=win, RxValid<=1, CommaDet<=1
  - good_cnt<=1, bad_cnt<=0
  - state<=VERIFY, or LOCKED if LOCK_CNT==1
- HUNT: no RxValid except on a realign event.
- VERIFY:
  - Aligned comma: good_cnt+1. When it reaches LOCK_CNT, go to LOCKED and clear bad_cnt.
  - Misaligned comma: realign event, stay in VERIFY.
  - Non-comma boundary word: no change.
- LOCKED:
  - Aligned comma: bad_cnt<=0.
  - Misaligned comma: bad_cnt+1, phase unchanged. When bad_cnt reaches LOSS_CNT, perform a realign event; state becomes VERIFY and Aligned drops.
- Counters saturate and never wrap. Each counter is $clog2(max+1) bits wide.

## Timing
- Reset (async assert, sync release) values:
  - RxParallel_10=0, RxValid=0, CommaDet=0, Aligned=0, AlignState=0
  - sh=0, phase=0, good_cnt=0, bad_cnt=0, watchdog counter=0
- Latency: the word whose last bit is sampled at edge N is on RxParallel_10 with RxValid=1 after edge N. RxValid lasts exactly one cycle.
- In VERIFY/LOCKED, RxValid pulses are exactly 10 cycles apart except across a realign event. A realign event pulses RxValid on its own edge, and the next pulse comes 10 cycles later.
- Aligned/AlignState update on the same edge as the RxValid of the deciding word.
- Reset mid-word discards the partial word. No RxValid is produced until a comma is found.

## Configuration
- RX_ALIGN_WATCHDOG_EN defined:
  - In LOCKED, a word counter increments at each boundary without an aligned comma and clears on an aligned comma.
  - When it reaches WDOG_WORDS: state<=HUNT, Aligned<=0, counters cleared, and the phase counter is left free-running.
- Undefined: no watchdog logic. WDOG_WORDS is ignored. Lock is lost only via LOSS_CNT.

## Structure
- Package rx_align_pkg holds:
  - state encodings HUNT/VERIFY/LOCKED as a 2-bit typedef
  - K28_5_RDN=10'h17C and K28_5_RDP=10'h283
- Sub-module rx_comma_detect: combinational 10-bit window compare returning the match flag. Kept separate so other comma sets can be added later.

## Test plan
- Reset_n low for 5 cycles, then idle zeros → all outputs 0, AlignState=0, no RxValid.
- 3 random bits, then repeated 10'h17C words (default params):
  - first RxValid on the edge completing the first comma
  - Aligned=1 on the third comma pulse
  - pulses every 10 cycles, all with CommaDet=1
- Locked stream, then insert 1 extra bit:
  - misaligned commas raise bad_cnt
  - on the 4th misaligned comma, AlignState=1 and Aligned=0, with RxValid realigned to the new boundary
  - 2 further commas give LOCKED
- Locked stream with alternating 10'h17C/10'h283 plus D-words (10'h2AA) → Aligned stays 1; CommaDet only on comma words.
- Reset_n pulsed low mid-word while LOCKED → immediate Aligned=0, AlignState=0, RxParallel_10=0; relock after 3 commas.
- With RX_ALIGN_WATCHDOG_EN and WDOG_WORDS=8: lock, then send 8 consecutive 10'h2AA words → AlignState=0 after the 8th word's RxValid. Without the macro → stays LOCKED.
